// File: rtl/sequential_subtractor_64bit_if.sv
// sequential_subtractor_64bit_if: start/busy/done handshake and operand/result bus of the sequential subtractor
interface sequential_subtractor_64bit_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;
    modport master (output start, in1, in2, b_in, input busy, done, diff, b_out, ovf);
    modport slave  (input start, in1, in2, b_in, output busy, done, diff, b_out, ovf);
endinterface

// File: rtl/sequential_subtractor_64bit.sv
// sequential_subtractor_64bit: diff = in1 - in2 - b_in, one SLICE-bit ripple-borrow slice per clock, LSB first
module sequential_subtractor_64bit #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input logic                          clk,
    input logic                          rst_n,
    sequential_subtractor_64bit_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic             r_brw, r_b_out, r_ovf;
    logic             w_accept, w_last;
    logic [SLICE:0]   w_slice;
    assign w_accept = bus.start && (r_state != CALC);
    assign w_last   = r_cnt == CW'(NSLICE - 1);
    // MSB of the SLICE+1 bit difference is the borrow into the next slice
    assign w_slice  = {1'b0, r_a[r_cnt*SLICE +: SLICE]} - {1'b0, r_b[r_cnt*SLICE +: SLICE]} - (SLICE+1)'(r_brw);
    always_comb begin
        w_next = r_state;
        if (r_state == CALC) w_next = w_last ? DONE : CALC;
        else w_next = w_accept ? CALC : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_brw   <= 1'b0;
            r_diff  <= '0;
            r_b_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == CALC) begin
                r_diff[r_cnt*SLICE +: SLICE] <= w_slice[SLICE-1:0];
                r_brw <= w_slice[SLICE];
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_b_out <= w_slice[SLICE];
                    r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_slice[SLICE-1] != r_a[WIDTH-1]);
                end
            end else if (w_accept) begin
                r_a   <= bus.in1;
                r_b   <= bus.in2;
                r_brw <= bus.b_in;
                r_cnt <= '0;
            end
        end
    end
    assign bus.busy  = r_state == CALC;
    assign bus.done  = r_state == DONE;
    assign bus.diff  = r_diff;
    assign bus.b_out = r_b_out;
    assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_sequential_subtractor_64bit.sv
// tb_sequential_subtractor_64bit: directed vector table, handshake corner sequences and random ops vs. an arithmetic model
module tb_sequential_subtractor_64bit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    sequential_subtractor_64bit_if bus ();
    sequential_subtractor_64bit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [63:0] in1;
        logic [63:0] in2;
        logic        b_in;
        logic [63:0] diff;
        logic        b_out;
        logic        ovf;
    } vec_t;
    vec_t vecs[6];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic bi,
                         output logic [63:0] d, output logic bo, output logic ov);
        d  = a - b - 64'(bi);
        bo = {1'b0, a} < ({1'b0, b} + 65'(bi));
        ov = (a[63] != b[63]) && (d[63] != a[63]);
    endtask
    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b, input logic bi,
                          input logic [63:0] ed, input logic eb, input logic eo);
        int cyc = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = a;
        bus.in2   = b;
        bus.b_in  = bi;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.in1   = {$urandom, $urandom};
        bus.in2   = {$urandom, $urandom};
        bus.b_in  = 1'($urandom);
        cyc = 1;
        check({name, " busy"}, 64'(bus.busy), 64'd1);
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'd5);
        check({name, " diff"}, bus.diff, ed);
        check({name, " b_out"}, 64'(bus.b_out), 64'(eb));
        check({name, " ovf"}, 64'(bus.ovf), 64'(eo));
    endtask
    initial begin
        logic [63:0] a, b, d;
        logic        bi, bo, ov;
        int          d1, d2, nd;
        vecs[0] = '{64'd98765432198765, 64'd12345678912345, 1'b0, 64'd86419753286420, 1'b0, 1'b0};
        vecs[1] = '{64'd98765432198765, 64'd12345678912345, 1'b1, 64'd86419753286419, 1'b0, 1'b0};
        vecs[2] = '{64'd12345678912345, 64'd98765432198765, 1'b0, 64'd0 - 64'd86419753286420, 1'b1, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[4] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.b_in  = 1'b0;
        rst_n     = 1'b0;
        #3;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset diff", bus.diff, 64'd0);
        check("reset b_out", 64'(bus.b_out), 64'd0);
        check("reset ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].in1, vecs[i].in2, vecs[i].b_in,
                                 vecs[i].diff, vecs[i].b_out, vecs[i].ovf);
        // start held high through CALC with new operands: ignored in CALC, accepted again in DONE
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = vecs[0].in1;
        bus.in2   = vecs[0].in2;
        bus.b_in  = 1'b0;
        d1 = 0;
        d2 = 0;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.in1  = vecs[3].in1;
                bus.in2  = vecs[3].in2;
                bus.b_in = 1'b0;
            end
            if (bus.done) begin
                if (d1 == 0) begin
                    d1 = c;
                    check("b2b first diff", bus.diff, vecs[0].diff);
                end else if (d2 == 0) begin
                    d2 = c;
                    bus.start = 1'b0;
                    check("b2b second diff", bus.diff, vecs[3].diff);
                    check("b2b second ovf", 64'(bus.ovf), 64'd1);
                end
            end
        end
        bus.start = 1'b0;
        check("b2b first done cycle", 64'(d1), 64'd5);
        check("b2b second done cycle", 64'(d2), 64'd10);
        // reset two cycles into CALC abandons the op immediately
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = vecs[2].in1;
        bus.in2   = vecs[2].in2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset done", 64'(bus.done), 64'd0);
        check("midreset diff", bus.diff, 64'd0);
        check("midreset b_out", 64'(bus.b_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        check("no activity after reset", 64'(nd), 64'd0);
        for (int i = 0; i < 40; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            bi = 1'($urandom);
            if ($urandom_range(3) == 0) a = ($urandom_range(1) == 0) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
            if ($urandom_range(3) == 0) b = ($urandom_range(1) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'd0;
            if ($urandom_range(7) == 0) b = a;
            model(a, b, bi, d, bo, ov);
            run_op($sformatf("rand%0d", i), a, b, bi, d, bo, ov);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
